// File: rtl/mist1032sa_bus_arbiter_2port.sv
// mist1032sa_bus_arbiter_2port: round-robin sharing of one pipelined memory port between fetch (A) and load/store (B).
// Define MIST1032SA_BUS_ARBITER_FIXED_PRIORITY_EN to make A win every tie instead of alternating.
module mist1032sa_bus_arbiter_2port #(
    parameter int DW  = 32,
    parameter int QD  = 8,
    parameter int QDN = 3
) (
    input  logic          iCLOCK,
    input  logic          inRESET,
    input  logic          iFLASH,
    input  logic          iA_REQ,
    output logic          oA_BUSY,
    input  logic [DW-1:0] iA_ADDR,
    input  logic          iA_RW,
    input  logic [DW-1:0] iA_DATA,
    output logic          oA_VALID,
    output logic [DW-1:0] oA_DATA,
    input  logic          iB_REQ,
    output logic          oB_BUSY,
    input  logic [DW-1:0] iB_ADDR,
    input  logic          iB_RW,
    input  logic [DW-1:0] iB_DATA,
    output logic          oB_VALID,
    output logic [DW-1:0] oB_DATA,
    output logic          oMEM_REQ,
    input  logic          iMEM_BUSY,
    output logic [DW-1:0] oMEM_ADDR,
    output logic          oMEM_RW,
    output logic [DW-1:0] oMEM_DATA,
    input  logic          iMEM_VALID,
    input  logic [DW-1:0] iMEM_DATA
);
    localparam int DRW = 16;
    localparam logic [QDN:0] QD_W = (QDN+1)'(QD);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t         state, state_next;
    logic [QD-1:0]  tag_q;
    logic [QDN-1:0] wr_ptr, rd_ptr;
    logic [QDN:0]   count;
    logic [DRW-1:0] drop;
    logic           rr;
    logic           go, a_ok, b_ok, grant_a, grant_b, grant, push, pop, dec;

    assign oMEM_REQ = state == ISSUE;
    assign oA_BUSY  = !grant_a;
    assign oB_BUSY  = !grant_b;

    always_comb begin
        go   = (state == IDLE || !iMEM_BUSY) && !iFLASH;
        a_ok = iA_REQ && (iA_RW || count < QD_W);
        b_ok = iB_REQ && (iB_RW || count < QD_W);
`ifdef MIST1032SA_BUS_ARBITER_FIXED_PRIORITY_EN
        grant_a = go && a_ok;
        grant_b = go && b_ok && !a_ok;
`else
        grant_a = go && a_ok && (!b_ok || !rr);
        grant_b = go && b_ok && (!a_ok || rr);
`endif
        grant = grant_a || grant_b;
        push  = grant && !(grant_a ? iA_RW : iB_RW);
        pop   = iMEM_VALID && drop == '0 && count != '0 && !iFLASH;
        // A response that lands on the flush cycle consumes one of the reads being discarded.
        dec   = iMEM_VALID && (drop != '0 || count != '0);
        state_next = (grant || (state == ISSUE && iMEM_BUSY)) ? ISSUE : IDLE;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state     <= IDLE;
            oMEM_ADDR <= '0;
            oMEM_RW   <= 1'b0;
            oMEM_DATA <= '0;
            oA_VALID  <= 1'b0;
            oB_VALID  <= 1'b0;
            oA_DATA   <= '0;
            oB_DATA   <= '0;
            tag_q     <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            drop      <= '0;
            rr        <= 1'b0;
        end else begin
            state <= state_next;
            if (grant) begin
                oMEM_ADDR <= grant_a ? iA_ADDR : iB_ADDR;
                oMEM_RW   <= grant_a ? iA_RW   : iB_RW;
                oMEM_DATA <= grant_a ? iA_DATA : iB_DATA;
                rr        <= grant_a;
            end
            if (iFLASH) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                drop   <= drop + DRW'(count) - DRW'(dec);
            end else begin
                if (push) begin
                    tag_q[wr_ptr] <= grant_b;
                    wr_ptr        <= wr_ptr + 1'b1;
                end
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count <= count + (QDN+1)'(push) - (QDN+1)'(pop);
                if (iMEM_VALID && drop != '0)
                    drop <= drop - 1'b1;
            end
            oA_VALID <= pop && !tag_q[rd_ptr];
            oB_VALID <= pop && tag_q[rd_ptr];
            if (pop && !tag_q[rd_ptr])
                oA_DATA <= iMEM_DATA;
            if (pop && tag_q[rd_ptr])
                oB_DATA <= iMEM_DATA;
        end
    end
endmodule

// File: tb/tb_mist1032sa_bus_arbiter_2port.sv
// tb_mist1032sa_bus_arbiter_2port: vector table, directed corner sequences and a random run against a queue-based model.
module tb_mist1032sa_bus_arbiter_2port;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush, a_req, a_rw, b_req, b_rw, mem_busy, mem_valid;
    logic [31:0] a_addr, a_data, b_addr, b_data, mem_data;
    logic        a_busy, b_busy, a_valid, b_valid, mem_req, mem_rw;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_wdata;
    int          tests = 0;
    int          fails = 0;

    bit          m_rr, m_pend, m_rw, m_va, m_vb;
    bit          m_q[$];
    int          m_drop;
    logic [31:0] m_addr, m_wdata, m_da, m_db;

    always #5 clk = ~clk;

    mist1032sa_bus_arbiter_2port dut (
        .iCLOCK(clk), .inRESET(rst_n), .iFLASH(flush),
        .iA_REQ(a_req), .oA_BUSY(a_busy), .iA_ADDR(a_addr), .iA_RW(a_rw), .iA_DATA(a_data),
        .oA_VALID(a_valid), .oA_DATA(a_rdata),
        .iB_REQ(b_req), .oB_BUSY(b_busy), .iB_ADDR(b_addr), .iB_RW(b_rw), .iB_DATA(b_data),
        .oB_VALID(b_valid), .oB_DATA(b_rdata),
        .oMEM_REQ(mem_req), .iMEM_BUSY(mem_busy), .oMEM_ADDR(mem_addr), .oMEM_RW(mem_rw),
        .oMEM_DATA(mem_wdata), .iMEM_VALID(mem_valid), .iMEM_DATA(mem_data)
    );

    typedef struct {
        logic ar, aw, br, bw, fl, ea, eb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        {flush, a_req, a_rw, b_req, b_rw, mem_busy, mem_valid} = '0;
        {a_addr, a_data, b_addr, b_data, mem_data} = '0;
    endtask

    task automatic model_reset();
        m_rr = 0; m_pend = 0; m_rw = 0; m_va = 0; m_vb = 0;
        m_q.delete();
        m_drop = 0;
        m_addr = '0; m_wdata = '0; m_da = '0; m_db = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_in();
        #2;
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_rw_data", {mem_rw, mem_wdata}, 0);
        chk("rst_valid", {a_valid, b_valid}, 0);
        chk("rst_rdata", a_rdata | b_rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic next();
        @(posedge clk); #1;
    endtask

    // Grant decision taken straight from the arbitration rules.
    task automatic arb(output bit ga, output bit gb);
        bit can, aok, bok;
        can = !m_pend || !mem_busy;
        aok = a_req && (a_rw || m_q.size() < 8);
        bok = b_req && (b_rw || m_q.size() < 8);
        ga = 0; gb = 0;
        if (can && !flush) begin
            if (aok && bok) begin
`ifdef MIST1032SA_BUS_ARBITER_FIXED_PRIORITY_EN
                ga = 1;
`else
                if (m_rr) gb = 1; else ga = 1;
`endif
            end else begin
                ga = aok; gb = bok;
            end
        end
    endtask

    task automatic model_step(input bit ga, input bit gb);
        int cnt;
        bit o;
        cnt = m_q.size();
        m_va = 0; m_vb = 0;
        if (flush) begin
            m_drop = m_drop + cnt - ((mem_valid && (m_drop > 0 || cnt > 0)) ? 1 : 0);
            m_q.delete();
        end else if (mem_valid) begin
            if (m_drop > 0) m_drop--;
            else if (cnt > 0) begin
                o = m_q.pop_front();
                if (o) begin m_vb = 1; m_db = mem_data; end
                else   begin m_va = 1; m_da = mem_data; end
            end
        end
        if (ga || gb) begin
            if (!(ga ? a_rw : b_rw)) m_q.push_back(gb);
            m_rr = ga;
            m_pend = 1;
            m_addr = ga ? a_addr : b_addr;
            m_rw = ga ? a_rw : b_rw;
            m_wdata = ga ? a_data : b_data;
        end else if (m_pend && !mem_busy) m_pend = 0;
    endtask

    vec_t vt[7];
    bit   ga, gb;

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 1, 1};
        vt[1] = '{1, 0, 0, 0, 0, 0, 1};
        vt[2] = '{0, 0, 1, 0, 0, 1, 0};
        vt[3] = '{1, 0, 1, 0, 0, 0, 1};
        vt[4] = '{1, 1, 1, 1, 0, 0, 1};
        vt[5] = '{0, 1, 1, 1, 0, 1, 0};
        vt[6] = '{1, 0, 1, 0, 1, 1, 1};
        clear_in();
        #3;
        do_reset();

        // Idle-state grant table; requests are withdrawn before each edge so nothing is accepted.
        for (int i = 0; i < 7; i++) begin
            next();
            a_req = vt[i].ar; a_rw = vt[i].aw; b_req = vt[i].br; b_rw = vt[i].bw; flush = vt[i].fl;
            #2;
            chk($sformatf("vec%0d_a_busy", i), a_busy, vt[i].ea);
            chk($sformatf("vec%0d_b_busy", i), b_busy, vt[i].eb);
            clear_in();
        end

        // Single A read with a zero-stall memory.
        do_reset();
        a_req = 1; a_rw = 0; a_addr = 32'h100;
        @(negedge clk); chk("rd_a_busy", a_busy, 0);
        next(); a_req = 0;
        @(negedge clk); chk("rd_mem_req", mem_req, 1); chk("rd_mem_addr", mem_addr, 32'h100); chk("rd_mem_rw", mem_rw, 0);
        next(); mem_valid = 1; mem_data = 32'hDEADBEEF;
        @(negedge clk); chk("rd_early_valid", a_valid, 0);
        next(); mem_valid = 0;
        @(negedge clk); chk("rd_a_valid", a_valid, 1); chk("rd_a_data", a_rdata, 32'hDEADBEEF); chk("rd_b_valid", b_valid, 0);

        // Memory stall holds the issued request and blocks both requesters.
        do_reset();
        a_req = 1; a_addr = 32'h200; mem_busy = 1;
        @(negedge clk); chk("stall_first_grant", a_busy, 0);
        next(); a_addr = 32'h300; b_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_addr", mem_addr, 32'h200);
            chk("stall_req", mem_req, 1);
            chk("stall_busy", {a_busy, b_busy}, 2'b11);
            next();
        end
        clear_in();

        // Full tag queue blocks reads but not writes.
        do_reset();
        b_req = 1; b_rw = 0;
        for (int i = 0; i < 8; i++) begin
            b_addr = 32'h40 + 32'(i * 4);
            @(negedge clk); chk("fill_b_busy", b_busy, 0);
            next();
        end
        a_req = 1; a_rw = 1; a_addr = 32'h80;
        @(negedge clk); chk("full_b_busy", b_busy, 1); chk("full_a_write", a_busy, 0);
        next(); a_req = 0; mem_valid = 1; mem_data = 32'h55;
        @(negedge clk); chk("full_b_busy2", b_busy, 1);
        next(); mem_valid = 0;
        @(negedge clk); chk("freed_b_busy", b_busy, 0); chk("freed_b_valid", b_valid, 1); chk("freed_b_data", b_rdata, 32'h55);
        next(); clear_in();

        // Flush on the same cycle as a response with two reads outstanding.
        do_reset();
        a_req = 1; a_addr = 32'h10;
        next(); a_addr = 32'h14;
        next(); a_req = 0; flush = 1; mem_valid = 1; mem_data = 32'h11;
        @(negedge clk); chk("flush_a_busy", a_busy, 1);
        next(); flush = 0; mem_data = 32'h22;
        @(negedge clk); chk("flush_valid0", a_valid | b_valid, 0);
        next(); mem_valid = 0; a_req = 1; a_addr = 32'h30;
        @(negedge clk); chk("flush_valid1", a_valid | b_valid, 0);
        next(); a_req = 0;
        next(); mem_valid = 1; mem_data = 32'h33;
        next(); mem_valid = 0;
        @(negedge clk); chk("flush_after_valid", a_valid, 1); chk("flush_after_data", a_rdata, 32'h33);
        next();

        // Random traffic against the reference model, with one mid-run reset.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i == 2000) do_reset();
            a_req = 1'($urandom_range(0, 1)); a_rw = ($urandom_range(0, 3) == 0);
            b_req = 1'($urandom_range(0, 1)); b_rw = ($urandom_range(0, 3) == 0);
            a_addr = $urandom; a_data = $urandom; b_addr = $urandom; b_data = $urandom;
            flush = ($urandom_range(0, 19) == 0);
            mem_busy = ($urandom_range(0, 2) == 0);
            mem_valid = ($urandom_range(0, 7) < 3);
            mem_data = $urandom;
            @(negedge clk);
            arb(ga, gb);
            chk("rnd_a_busy", a_busy, !ga);
            chk("rnd_b_busy", b_busy, !gb);
            chk("rnd_mem_req", mem_req, m_pend);
            chk("rnd_mem_addr", mem_addr, m_addr);
            chk("rnd_mem_rw", mem_rw, m_rw);
            chk("rnd_mem_data", mem_wdata, m_wdata);
            chk("rnd_valid", {a_valid, b_valid}, {m_va, m_vb});
            chk("rnd_a_data", a_rdata, m_da);
            chk("rnd_b_data", b_rdata, m_db);
            @(posedge clk);
            model_step(ga, gb);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
